carry_normalizer: RTL and testbench



---
 rtl/carry_normalizer.sv | 100 ++++++++++
 tb/tb_carry_normalizer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/carry_normalizer.sv
// Carry normalizer: folds redundant 48-bit column sums into canonical LIMB_W-bit
// limbs, least significant first, then emits a fixed number of carry-flush limbs.
module carry_normalizer #(
  parameter int LIMB_W = 17,
  parameter int FLUSH  = (49 - LIMB_W + LIMB_W - 1) / LIMB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [47:0]       in_col,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] out_limb,
  output logic              out_last
);

  localparam int CW = 49 - LIMB_W;
  localparam int FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

  localparam logic [0:0] S_ACC   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [CW-1:0]     carry_q, carry_d;
  logic [LIMB_W-1:0] limb_q, limb_d;
  logic              ov_q, ov_d;
  logic              ol_q, ol_d;

  logic        slot, in_fire, flush_end;
  logic [48:0] sum, cext;

  always_comb begin
    slot      = !ov_q || out_ready;
    in_ready  = (state_q == S_ACC) && slot;
    in_fire   = in_valid && in_ready;
    flush_end = (fcnt_q == FW'(FLUSH - 1));
    // Carry is zero-extended to 49 bits so wide limbs (LIMB_W > CW) slice cleanly.
    cext      = {{LIMB_W{1'b0}}, carry_q};
    sum       = {1'b0, in_col} + cext;

    state_d = state_q;
    fcnt_d  = fcnt_q;
    carry_d = carry_q;
    limb_d  = limb_q;
    ov_d    = ov_q;
    ol_d    = ol_q;

    if (ov_q && out_ready) begin
      ov_d = 1'b0;
      ol_d = 1'b0;
    end

    if (in_fire) begin
      limb_d  = sum[LIMB_W-1:0];
      carry_d = CW'(sum >> LIMB_W);
      ov_d    = 1'b1;
      ol_d    = 1'b0;
      if (in_last) begin
        state_d = S_FLUSH;
        fcnt_d  = '0;
      end
    end else if (state_q == S_FLUSH && slot) begin
      limb_d  = cext[LIMB_W-1:0];
      carry_d = CW'(cext >> LIMB_W);
      ov_d    = 1'b1;
      ol_d    = flush_end;
      fcnt_d  = FW'(fcnt_q + 1'b1);
      if (flush_end) begin
        carry_d = '0;
        state_d = S_ACC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ACC;
      fcnt_q  <= '0;
      carry_q <= '0;
      limb_q  <= '0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      carry_q <= carry_d;
      limb_q  <= limb_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
    end
  end

  assign out_valid = ov_q;
  assign out_limb  = limb_q;
  assign out_last  = ol_q;

endmodule

// File: tb/tb_carry_normalizer.sv
// Bench for carry_normalizer: directed vector table, back-to-back and reset
// sequences, and random operands under random backpressure against a bignum sum.
module tb_carry_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [47:0] in_col;
  logic        out_valid, out_ready, out_last;
  logic [16:0] out_limb;

  carry_normalizer #(.LIMB_W(17)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_limb(out_limb), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] col;
    logic        last;
  } in_t;

  typedef struct {
    int              ncol;
    logic [1:0][47:0] col;
    logic [3:0][16:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  in_t         pend[$];
  logic [16:0] exp_l[$];
  logic        exp_last[$];

  bit          rnd_rdy = 1'b0;
  bit          counting = 1'b0;
  int          low_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [16:0] stall_limb;
  logic        stall_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later (inputs and regs stable until posedge).
  task automatic cycle();
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pend.size() > 0) begin
      in_valid = 1'b1;
      in_col   = pend[0].col;
      in_last  = pend[0].last;
    end else begin
      in_valid = 1'b0;
      in_col   = '0;
      in_last  = 1'b0;
    end
    #1;
    if (stall_prev) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_limb", 64'(out_limb), 64'(stall_limb));
      check("stall_last", 64'(out_last), 64'(stall_last));
    end
    if (out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
    stall_prev = out_valid && !out_ready;
    stall_limb = out_limb;
    stall_last = out_last;
    if (out_valid && out_ready) begin
      if (exp_l.size() == 0) check("extra_limb", 64'd1, 64'd0);
      else begin
        check("limb", 64'(out_limb), 64'(exp_l.pop_front()));
        check("last", 64'(out_last), 64'(exp_last.pop_front()));
      end
    end
    if (!rnd_rdy && counting) begin
      if (in_ready) begin
        check("ready_gap", 64'(low_cnt), 64'd2);
        counting = 1'b0;
      end else low_cnt++;
    end
    if (in_valid && in_ready) begin
      if (in_last && !rnd_rdy) begin
        counting = 1'b1;
        low_cnt  = 0;
      end
      pend.delete(0);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_l.size() > 0 || pend.size() > 0) && n < 4000) begin
      cycle();
      n++;
    end
    if (exp_l.size() > 0 || pend.size() > 0) check("drain_timeout", 64'(exp_l.size()), 64'd0);
    repeat (4) cycle();
  endtask

  task automatic push_vec(input vec_t v);
    for (int i = 0; i < v.ncol; i++) pend.push_back('{col: v.col[i], last: (i == v.ncol - 1)});
    for (int k = 0; k < v.ncol + 2; k++) begin
      exp_l.push_back(v.exp[k]);
      exp_last.push_back(k == v.ncol + 1);
    end
  endtask

  vec_t vt[4];

  initial begin
    vt[0].ncol = 1; vt[0].col = '0; vt[0].exp = '0;
    vt[0].col[0] = 48'hFFFF_FFFF_FFFF;
    vt[0].exp[0] = 17'h1FFFF; vt[0].exp[1] = 17'h1FFFF; vt[0].exp[2] = 17'h03FFF;
    vt[1].ncol = 2; vt[1].col = '0; vt[1].exp = '0;
    vt[1].col[0] = 48'hFFFF_FFFF_FFFF; vt[1].col[1] = 48'hFFFF_FFFF_FFFF;
    vt[1].exp[0] = 17'h1FFFF; vt[1].exp[1] = 17'h1FFFE;
    vt[1].exp[2] = 17'h03FFF; vt[1].exp[3] = 17'h04000;
    vt[2].ncol = 2; vt[2].col = '0; vt[2].exp = '0;
    vt[2].col[0] = 48'h1FFFF; vt[2].col[1] = 48'h1;
    vt[2].exp[0] = 17'h1FFFF; vt[2].exp[1] = 17'h1;
    vt[3].ncol = 1; vt[3].col = '0; vt[3].exp = '0;
    vt[3].col[0] = 48'h3_0005;
    vt[3].exp[0] = 17'h10005; vt[3].exp[1] = 17'h1;

    rst = 1'b1; in_valid = 1'b0; in_col = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_limb", 64'(out_limb), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 3; v++) begin
      push_vec(vt[v]);
      drain();
    end

    // Back-to-back operands with in_valid held high across the boundary.
    push_vec(vt[0]);
    push_vec(vt[3]);
    drain();

    // Reset while flushing with a limb pending.
    pend.push_back('{col: 48'hFFFF_FFFF_FFFF, last: 1'b1});
    exp_l.push_back(17'h1FFFF); exp_last.push_back(1'b0);
    exp_l.push_back(17'h1FFFF); exp_last.push_back(1'b0);
    exp_l.push_back(17'h03FFF); exp_last.push_back(1'b1);
    cycle();
    #2;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'd0);
    check("rst_async_ready", 64'(in_ready), 64'd1);
    pend.delete(); exp_l.delete(); exp_last.delete();
    counting = 1'b0; stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pend.push_back('{col: 48'h5, last: 1'b1});
    exp_l.push_back(17'h5); exp_last.push_back(1'b0);
    exp_l.push_back(17'h0); exp_last.push_back(1'b0);
    exp_l.push_back(17'h0); exp_last.push_back(1'b1);
    drain();

    // Random operands, random backpressure, expected limbs sliced from an exact bignum.
    rnd_rdy = 1'b1;
    for (int op = 0; op < 200; op++) begin
      int n;
      logic [399:0] big;
      logic [47:0]  col;
      n   = $urandom_range(1, 20);
      big = '0;
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0:       col = 48'hFFFF_FFFF_FFFF;
          1:       col = 48'($urandom_range(0, 3));
          default: col = {16'($urandom), 32'($urandom)};
        endcase
        big = big + (400'(col) << (17 * i));
        pend.push_back('{col: col, last: (i == n - 1)});
      end
      for (int k = 0; k < n + 2; k++) begin
        exp_l.push_back(big[17 * k +: 17]);
        exp_last.push_back(k == n + 1);
      end
      if (op % 10 == 9) drain();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
